id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Parametrised decode stage plus ID/EX pipeline boundary for the 5-stage Minisys pipeline.
- Contains the register file, 16-bit immediate extension, load-use hazard detection, and an ID/EX register with hold and flush/bubble control.
- Sits between the IF/ID register (instruction source) and the EXE stage; the WB stage writes back into it.
- Control decode is external; the decoded control word enters on ctrl_d.

Parameters:
- XLEN, 32, datapath width (register, PC+4 and immediate width); must be ≥ 16.
- NREG, 32, number of architectural registers; power of two, ≥ 2.
- AW, $clog2(NREG), register address width; derived, not overridden.
- CTRL_W, 15, width of the decoded control word carried to EXE.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  reset.
- instr_d  in  32  instruction in ID.
- pcplus4_d  in  XLEN  PC+4 of the ID instruction.
- valid_d  in  1  ID instruction is valid.
- ctrl_d  in  CTRL_W  decoded control word for the ID instruction.
- memread_d  in  1  ID instruction is a load.
- ext_zero_d  in  1  1 = zero-extend imm16, 0 = sign-extend.
- wb_we  in  1  WB write enable.
- wb_wn  in  AW  WB write address.
- wb_wd  in  XLEN  WB write data.
- flush_e  in  1  squash the ID instruction (branch/jump resolved in EXE).
- hold_e  in  1  freeze the ID/EX register (downstream stall).
- stall_d  out  1  freeze PC and IF/ID.
- valid_e, memread_e  out  1 each  registered valid and load flag.
- ctrl_e  out  CTRL_W  registered control word.
- rd1_e, rd2_e  out  XLEN each  registered register-file read data.
- rs_e, rt_e, rd_e  out  AW each  registered register numbers (forwarding and write-back selection).
- shamt_e  out  5  registered shift amount.
- imm_e  out  XLEN  registered extended immediate.
- pcplus4_e  out  XLEN  registered PC+4.

Behaviour:
- Interface: one clock, clk. Reset clrn is asynchronous and active-low.
- Reset: all E outputs and all register-file entries go to 0. stall_d is combinational and reads 0 under reset.
- Field slicing from instr_d:
  - rs = [25:21], rt = [20:16], rd = [15:11] (each zero-padded or truncated to AW).
  - shamt = [10:6], imm16 = [15:0].
- Register file:
  - NREG x XLEN, asynchronous read on rs and rt.
  - Written on the rising edge when wb_we && wb_wn != 0.
  - Register 0 always reads 0; writes to it are ignored.
- Immediate: imm_e source = {XLEN-16 copies of (ext_zero_d ? 0 : imm16[15]), imm16}.
- Load-use hazard:
  - load_use = valid_e & memread_e & valid_d & (rt_e != 0) & ((rt_e == rs) | (rt_e == rt)).
  - The rt compare is applied conservatively, even for I-type instructions.
- stall_d = hold_e | (load_use & ~flush_e).
- ID/EX update at each rising edge, highest priority first:
  1. hold_e: every E register keeps its value (hold beats flush; flush_e is ignored that cycle, and the upstream branch unit must keep flush_e asserted).
  2. flush_e or load_use: bubble; every E field is loaded with 0 (valid_e = 0, ctrl_e = 0, memread_e = 0, data fields 0).
  3. Otherwise: load the D-side values; valid_e = valid_d.
- Latency: one cycle from D inputs to E outputs.
- A stalled instruction stays in ID and re-evaluates load_use next cycle. After one bubble, load_use clears because valid_e = 0.
- Reset asserted mid-stall: state clears immediately; the first post-reset edge loads normally.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: write-first read bypass. If wb_we && wb_wn != 0 && wb_wn equals rs (or rt), the corresponding read returns wb_wd in the same cycle, so the value captured into rd1_e/rd2_e is the new one.
- Undefined: reads return the pre-write array contents. The EXE forwarding unit must cover the WB-to-ID distance.

Decomposition:
- Package id_pkg:
  - XLEN and CTRL_W defaults.
  - Instruction field bit-position localparams.
  - Control-word bit index localparams (regwrite, mem2reg, branch, jump, alusrc, regdst, lwsw, alucontrol[3:0], memwrite[3:0]).
  - BUBBLE_CTRL = 0.
- One sub-module: id_regfile (NREG x XLEN array, r0 hardwiring, optional bypass).
- Hazard logic and the ID/EX register stay in id_ex_stage.

Test Plan:
- Reset: drive clrn = 0 mid-run → all E outputs 0 and registers read 0. Write r5 = 0x1234 via WB, add rs=5 → rd1_e = 0x00001234 one cycle later.
- Pass-through: imm16 = 0x8001 with ext_zero_d = 0 → imm_e = 0xFFFF8001; with ext_zero_d = 1 → 0x00008001. pcplus4_d = 0x40 → pcplus4_e = 0x40.
- Load-use: lw rt=8 in E (memread_e = 1, valid_e = 1), ID instr rs=8 → stall_d = 1, next edge valid_e = 0 and ctrl_e = 0. The following edge loads the dependent instruction and stall_d = 0. Repeat with rt_e = 0 → no stall.
- Flush vs load-use: flush_e = 1 together with the load-use condition → stall_d = 0, bubble inserted. hold_e = 1 with flush_e = 1 → E unchanged, stall_d = 1.
- r0 write: wb_we = 1, wb_wn = 0, wb_wd = 0xDEADBEEF; read rs=0 → rd1_e = 0.
- Bypass: wb writes r3 = 0xA5A5A5A5 in the same cycle ID reads rs=3 → rd1_e = 0xA5A5A5A5 with ID_WB_BYPASS_EN defined, old r3 value without it.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the Minisys ID stage: defaults, instruction field positions,
// control-word bit indices and the ID/EX update actions.
package id_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CTRL_W_DEF = 15;

  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FIELD_W   = 5;
  localparam int IMM_W     = 16;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEM2REG   = 1;
  localparam int CTRL_BRANCH    = 2;
  localparam int CTRL_JUMP      = 3;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 5;
  localparam int CTRL_LWSW      = 6;
  localparam int CTRL_ALUCTL_LSB = 7;
  localparam int CTRL_MEMWR_LSB  = 11;

  localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    EX_LOAD   = 2'd0,
    EX_BUBBLE = 2'd1,
    EX_HOLD   = 2'd2
  } exAction_t;

  function automatic logic [FIELD_W-1:0] instrField(input logic [31:0] instr, input int lsb);
    return instr[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file, two async read ports, r0 hardwired to zero.
// Optional write-first bypass when ID_WB_BYPASS_EN is defined.
module id_regfile import id_pkg::*; #(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic            we,
  input  logic [AW-1:0]   wn,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wrEn;

  assign wrEn = we && (wn != '0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[wn] <= wd;
    end
  end

  // wrEn already excludes r0, so the bypass can never make r0 non-zero
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs[ra1];
    rd2 = (ra2 == '0) ? '0 : regs[ra2];
`ifdef ID_WB_BYPASS_EN
    if (wrEn && (wn == ra1)) rd1 = wd;
    if (wrEn && (wn == ra2)) rd2 = wd;
`endif
  end

endmodule

// File: rtl/id_ex_stage.sv
// Minisys decode stage and ID/EX register: register file, immediate extension,
// load-use detection, hold/flush control. Optional feature macro: ID_WB_BYPASS_EN.
module id_ex_stage import id_pkg::*; #(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREG   = 32,
  parameter  int CTRL_W = CTRL_W_DEF,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic              valid_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              memread_d,
  input  logic              ext_zero_d,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_wn,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush_e,
  input  logic              hold_e,
  output logic              stall_d,
  output logic              valid_e,
  output logic              memread_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [AW-1:0]     rs_e,
  output logic [AW-1:0]     rt_e,
  output logic [AW-1:0]     rd_e,
  output logic [4:0]        shamt_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pcplus4_e
);

  logic [AW-1:0]   rsD, rtD, rdD;
  logic [4:0]      shamtD;
  logic [XLEN-1:0] immD, rd1D, rd2D;
  logic            loadUse;
  logic            unusedOpcode;
  exAction_t       action;

  function automatic logic [XLEN-1:0] extImm(input logic [IMM_W-1:0] imm16, input logic zeroExt);
    logic signed [IMM_W-1:0] simm;
    simm = $signed(imm16);
    if (zeroExt) return XLEN'(imm16);
    return XLEN'(simm);
  endfunction

  assign rsD          = AW'(instrField(instr_d, RS_LSB));
  assign rtD          = AW'(instrField(instr_d, RT_LSB));
  assign rdD          = AW'(instrField(instr_d, RD_LSB));
  assign shamtD       = instrField(instr_d, SHAMT_LSB);
  assign immD         = extImm(instr_d[IMM_W-1:0], ext_zero_d);
  assign unusedOpcode = ^instr_d[31:26];

  id_regfile #(.XLEN(XLEN), .NREG(NREG)) uRegfile (
    .clk  (clk),
    .clrn (clrn),
    .ra1  (rsD),
    .ra2  (rtD),
    .we   (wb_we),
    .wn   (wb_wn),
    .wd   (wb_wd),
    .rd1  (rd1D),
    .rd2  (rd2D)
  );

  // rt is compared even for I-type consumers: an occasional spurious bubble is cheaper than decoding use
  assign loadUse = valid_e & memread_e & valid_d & (rt_e != '0) & ((rt_e == rsD) | (rt_e == rtD));
  assign stall_d = clrn & (hold_e | (loadUse & ~flush_e));

  always_comb begin
    action = EX_LOAD;
    if (hold_e)                  action = EX_HOLD;
    else if (flush_e || loadUse) action = EX_BUBBLE;
  end

  // ID/EX boundary
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_e   <= 1'b0;
      memread_e <= 1'b0;
      ctrl_e    <= '0;
      rd1_e     <= '0;
      rd2_e     <= '0;
      rs_e      <= '0;
      rt_e      <= '0;
      rd_e      <= '0;
      shamt_e   <= '0;
      imm_e     <= '0;
      pcplus4_e <= '0;
    end else begin
      case (action)
        EX_LOAD: begin
          valid_e   <= valid_d;
          memread_e <= memread_d;
          ctrl_e    <= ctrl_d;
          rd1_e     <= rd1D;
          rd2_e     <= rd2D;
          rs_e      <= rsD;
          rt_e      <= rtD;
          rd_e      <= rdD;
          shamt_e   <= shamtD;
          imm_e     <= immD;
          pcplus4_e <= pcplus4_d;
        end
        EX_BUBBLE: begin
          valid_e   <= 1'b0;
          memread_e <= 1'b0;
          ctrl_e    <= CTRL_W'(BUBBLE_CTRL);
          rd1_e     <= '0;
          rd2_e     <= '0;
          rs_e      <= '0;
          rt_e      <= '0;
          rd_e      <= '0;
          shamt_e   <= '0;
          imm_e     <= '0;
          pcplus4_e <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, hazard sequences and
// randomized traffic against a register-array / pipeline-slot reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] instr_d, pcplus4_d, wb_wd;
  logic        valid_d, memread_d, ext_zero_d, wb_we, flush_e, hold_e;
  logic [14:0] ctrl_d;
  logic [4:0]  wb_wn;
  logic        stall_d, valid_e, memread_e;
  logic [14:0] ctrl_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pcplus4_e;
  logic [4:0]  rs_e, rt_e, rd_e, shamt_e;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .clrn(clrn), .instr_d(instr_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .memread_d(memread_d), .ext_zero_d(ext_zero_d), .wb_we(wb_we),
    .wb_wn(wb_wn), .wb_wd(wb_wd), .flush_e(flush_e), .hold_e(hold_e), .stall_d(stall_d),
    .valid_e(valid_e), .memread_e(memread_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .shamt_e(shamt_e), .imm_e(imm_e), .pcplus4_e(pcplus4_e)
  );

  typedef struct packed {
    logic        valid;
    logic        memread;
    logic [14:0] ctrl;
    logic [31:0] rd1, rd2;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm, pc;
  } eState_t;

  typedef struct {
    logic [31:0] instr, pc;
    logic        ez;
    logic [14:0] ctrl;
    logic [31:0] eImm, eRd1, eRd2;
    logic [4:0]  eRd, eShamt;
  } vec_t;

  eState_t     mE, act, snap;
  logic [31:0] mRegs [32];
  logic        lastStall;
  int          nVec = 0, nBad = 0;
  vec_t        vecs [4];
  logic [31:0] expBypass;

  assign act = {valid_e, memread_e, ctrl_e, rd1_e, rd2_e, rs_e, rt_e, rd_e, shamt_e, imm_e, pcplus4_e};

  task automatic check(input string name, input logic [255:0] a, input logic [255:0] e);
    nVec++;
    if (a !== e) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic logic [31:0] readReg(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_wn == a) return wb_wd;
`endif
    return mRegs[a];
  endfunction

  // Model one clock: predict stall and the next pipeline slot, then compare after the edge.
  task automatic tick(input string name);
    logic [4:0] rs, rt;
    logic       dep, expStall;
    eState_t    nE;
    rs  = instr_d[25:21];
    rt  = instr_d[20:16];
    dep = mE.valid && mE.memread && valid_d && (mE.rt != 0) && (mE.rt == rs || mE.rt == rt);
    expStall = hold_e || (dep && !flush_e);
    if (hold_e) nE = mE;
    else if (flush_e || dep) nE = '0;
    else begin
      nE.valid = valid_d;    nE.memread = memread_d;   nE.ctrl = ctrl_d;
      nE.rd1 = readReg(rs);  nE.rd2 = readReg(rt);
      nE.rs = rs;            nE.rt = rt;               nE.rd = instr_d[15:11];
      nE.shamt = instr_d[10:6];
      nE.imm = ext_zero_d ? {16'h0, instr_d[15:0]} : {{16{instr_d[15]}}, instr_d[15:0]};
      nE.pc = pcplus4_d;
    end
    #1;
    lastStall = stall_d;
    check({name, " stall"}, stall_d, expStall);
    @(posedge clk);
    if (wb_we && wb_wn != 0) mRegs[wb_wn] = wb_wd;
    mE = nE;
    #1;
    check({name, " E"}, act, mE);
  endtask

  task automatic idle();
    instr_d = 0; pcplus4_d = 0; valid_d = 0; ctrl_d = 0; memread_d = 0; ext_zero_d = 0;
    wb_we = 0; wb_wn = 0; wb_wd = 0; flush_e = 0; hold_e = 0;
  endtask

  task automatic doReset(input string name);
    clrn = 1'b0;
    hold_e = 1'b1;
    #1;
    mE = '0;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
    check({name, " E zero"}, act, 256'h0);
    check({name, " stall"}, stall_d, 1'b0);
    idle();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic wbWrite(input logic [4:0] n, input logic [31:0] d);
    idle();
    wb_we = 1; wb_wn = n; wb_wd = d;
    tick("wb write");
    wb_we = 0;
  endtask

  task automatic setId(input logic [31:0] ins, input logic mr, input logic [14:0] c);
    instr_d = ins; memread_d = mr; ctrl_d = c; valid_d = 1; pcplus4_d = 32'h100;
  endtask

  initial begin
    vecs[0] = '{32'h00A08001, 32'h40, 1'b0, 15'h1234, 32'hFFFF8001, 32'h1234, 32'h0,    5'd16, 5'd0};
    vecs[1] = '{32'h00A08001, 32'h44, 1'b1, 15'h0001, 32'h00008001, 32'h1234, 32'h0,    5'd16, 5'd0};
    vecs[2] = '{32'h000007C0, 32'h48, 1'b0, 15'h7FFF, 32'h000007C0, 32'h0,    32'h0,    5'd0,  5'd31};
    vecs[3] = '{32'h00057FFF, 32'h4C, 1'b0, 15'h0000, 32'h00007FFF, 32'h0,    32'h1234, 5'd15, 5'd31};

    idle();
    clrn = 1'b0;
    #2;
    doReset("reset0");
    wbWrite(5'd5, 32'h1234);
    wbWrite(5'd3, 32'h11111111);

    for (int i = 0; i < 4; i++) begin
      idle();
      instr_d = vecs[i].instr; pcplus4_d = vecs[i].pc; ext_zero_d = vecs[i].ez;
      ctrl_d = vecs[i].ctrl; valid_d = 1;
      tick("table");
      check("table imm", imm_e, vecs[i].eImm);
      check("table rd1", rd1_e, vecs[i].eRd1);
      check("table rd2", rd2_e, vecs[i].eRd2);
      check("table rd", rd_e, vecs[i].eRd);
      check("table shamt", shamt_e, vecs[i].eShamt);
      check("table pc", pcplus4_e, vecs[i].pc);
    end

    // load-use: lw rt=8, then a consumer of r8
    idle(); setId(32'h00080000, 1'b1, 15'h0043); tick("lw r8");
    setId(32'h01000000, 1'b0, 15'h0021); tick("lu bubble");
    check("lu stall high", lastStall, 1'b1);
    check("lu bubble valid", valid_e, 1'b0);
    check("lu bubble ctrl", ctrl_e, 15'h0);
    tick("lu release");
    check("lu release stall", lastStall, 1'b0);
    check("lu release valid", valid_e, 1'b1);
    check("lu release ctrl", ctrl_e, 15'h0021);
    check("lu release rs", rs_e, 5'd8);

    // rt_e = 0 never stalls
    setId(32'h00000000, 1'b1, 15'h0043); tick("lw r0");
    setId(32'h00000000, 1'b0, 15'h0021); tick("lw r0 dep");
    check("r0 load no stall", lastStall, 1'b0);
    check("r0 load valid", valid_e, 1'b1);

    // flush together with load-use: no stall, bubble
    setId(32'h00080000, 1'b1, 15'h0043); tick("lw r8 b");
    setId(32'h01000000, 1'b0, 15'h0021); flush_e = 1; tick("flush+lu");
    flush_e = 0;
    check("flush lu stall", lastStall, 1'b0);
    check("flush lu valid", valid_e, 1'b0);

    // hold beats flush
    setId(32'h01000000, 1'b0, 15'h0021); tick("pre hold");
    snap = act;
    setId(32'h00A08001, 1'b1, 15'h7FFF); hold_e = 1; flush_e = 1; tick("hold+flush");
    hold_e = 0; flush_e = 0;
    check("hold stall", lastStall, 1'b1);
    check("hold keeps E", act, snap);

    // bypass vs pre-write read
    idle(); setId(32'h00600000, 1'b0, 15'h1);
    wb_we = 1; wb_wn = 5'd3; wb_wd = 32'hA5A5A5A5; tick("bypass");
`ifdef ID_WB_BYPASS_EN
    expBypass = 32'hA5A5A5A5;
`else
    expBypass = 32'h11111111;
`endif
    check("bypass rd1", rd1_e, expBypass);

    // r0 write ignored
    idle(); wb_we = 1; wb_wn = 0; wb_wd = 32'hDEADBEEF; tick("r0 write");
    idle(); setId(32'h00000000, 1'b0, 15'h1); tick("r0 read");
    check("r0 rd1", rd1_e, 32'h0);

    for (int n = 0; n < 400; n++) begin
      instr_d    = $urandom;
      instr_d[25:21] = 5'($urandom_range(0, 7));
      instr_d[20:16] = 5'($urandom_range(0, 7));
      pcplus4_d  = $urandom;
      valid_d    = ($urandom_range(0, 3) != 0);
      memread_d  = ($urandom_range(0, 2) == 0);
      ctrl_d     = 15'($urandom);
      ext_zero_d = 1'($urandom);
      wb_we      = 1'($urandom);
      wb_wn      = 5'($urandom_range(0, 7));
      wb_wd      = $urandom;
      hold_e     = ($urandom_range(0, 7) == 0);
      flush_e    = ($urandom_range(0, 7) == 0);
      tick("random");
    end

    // reset in the middle of a load-use stall
    idle(); setId(32'h00080000, 1'b1, 15'h0043); tick("lw pre-reset");
    setId(32'h01000000, 1'b0, 15'h0021);
    #1;
    check("pre-reset stall", stall_d, 1'b1);
    doReset("reset mid");
    setId(32'h00A00000, 1'b0, 15'h0055); tick("post-reset load");
    check("post-reset valid", valid_e, 1'b1);
    check("post-reset rd1", rd1_e, 32'h0);
    wbWrite(5'd5, 32'h1234);
    setId(32'h00A00000, 1'b0, 15'h0055); tick("r5 readback");
    check("r5 readback", rd1_e, 32'h00001234);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
